bcd_time_counter: RTL and testbench
===================================

Name: bcd_time_counter

Overview:
- Timekeeping stage directly downstream of the 1 Hz frequency divider.
- Samples the divider's slow square-wave output in the main clock domain and detects its rising edge to form a one-cycle tick.
- Counts hh:mm:ss in packed BCD and feeds the display and alarm logic.
- Supports run/stop control and a validated time-load handshake.

Parameters:
- HOUR_LIMIT, 24, hour modulus in the range 1..24; hours count 0..HOUR_LIMIT-1.
- SEC_LIMIT, 60, seconds and minutes modulus; fixed at 60 in normal use, reducible for simulation only.

Ports:
- clock_in  input  1  system clock (100 MHz); the only clock.
- reset  input  1  synchronous, active-high reset.
- slow_clk_in  input  1  divider output, synchronous to clock_in; each rising edge is one count event.
- run  input  1  1 = count ticks, 0 = hold (ticks are discarded).
- load_valid  input  1  load request.
- load_ready  output  1  block can accept a load this cycle.
- load_hh  input  8  BCD hours {tens, units}.
- load_mm  input  8  BCD minutes.
- load_ss  input  8  BCD seconds.
- hours  output  8  BCD hours.
- minutes  output  8  BCD minutes.
- seconds  output  8  BCD seconds.
- sec_pulse  output  1  one-cycle pulse for each counted second.
- day_pulse  output  1  one-cycle pulse on wrap to 00:00:00.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Clocking and reset:
  - One clock (clock_in), synchronous active-high reset (reset).
  - Reset sets hours, minutes and seconds to 0x00.
  - Reset clears sec_pulse, day_pulse and load_err to 0 and sets load_ready to 1.
  - Reset sets the edge-detect register slow_q to 1, so a slow_clk_in already high at reset release produces no tick.
  - State after reset is READY.
- Tick detection:
  - tick = slow_clk_in & ~slow_q, and slow_q <= slow_clk_in every cycle.
  - Counters and sec_pulse update on the same clock edge that tick is evaluated. Outputs are therefore visible one cycle after slow_clk_in is first sampled high.
- Counting (on tick & run & no accepted load):
  - Seconds increment in BCD (units 9 -> 0 carries into tens). At SEC_LIMIT-1 seconds wrap to 00 and carry into minutes.
  - Minutes behave the same way and carry into hours. Hours wrap at HOUR_LIMIT-1 to 00.
  - All three fields update atomically on one edge.
  - sec_pulse = 1 for that cycle.
  - day_pulse = 1 only on the 23:59:59 -> 00:00:00 transition (default parameters).
  - With run = 0, ticks are dropped, no pulses are produced, and the edge detector still tracks slow_clk_in.
- State machine, two states:
  - READY: load_ready = 1.
  - If load_valid = 1 and the load values are legal, capture load_hh, load_mm and load_ss into the outputs at this edge and go to ACK.
  - If load_valid = 1 and the load is illegal, pulse load_err, keep the current time and stay in READY.
  - ACK: load_ready = 0 for exactly one cycle, then go to READY unconditionally. load_valid is ignored in ACK. Ticks are counted normally in ACK.
- Legality check:
  - Every BCD nibble must be ≤ 9.
  - Tens of seconds and tens of minutes must be ≤ 5.
  - Hours value must be < HOUR_LIMIT.
- Simultaneous events:
  - Tick and accepted load in the same cycle: the load wins, the tick is discarded, and sec_pulse/day_pulse stay 0.
  - Tick and rejected load in the same cycle: the tick counts normally and load_err pulses.
- Reset mid-operation: reset has priority over load and tick, and any pending ACK is abandoned.
- Widths and pulses:
  - All arithmetic is per-nibble, 4 bits, with no binary intermediate.
  - Every output is registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package time_pkg:
  - typedef bcd2_t (logic [7:0]).
  - typedef state_t enum {READY, ACK}.
  - Constants BCD_MAX_DIGIT = 9 and SEC_TENS_MAX = 5.
  - Function is_legal_time().
- Sub-module bcd_mod_counter, instantiated three times (ss, mm, hh):
  - Parameter MODULUS.
  - Ports: clock_in, reset, inc, load, load_val, value[7:0], carry_out.
  - carry_out is combinational: inc & (value == MODULUS-1).

Test Plan:
- Reset released with slow_clk_in = 1 -> no sec_pulse. The next 0→1 edge of slow_clk_in with run = 1 gives seconds = 0x01 one cycle later and sec_pulse high for exactly 1 cycle.
- Load 23:59:58 then two ticks -> 23:59:59, then 00:00:00. day_pulse is 1 on the second tick only. load_ready is 0 for exactly one cycle after the load.
- Load 0x09:0x59:0x09 -> accepted. Then load hh = 0x24, mm = 0x60, ss = 0x1A (each illegal in turn) -> load_err pulses each time and the time stays 09:59:09.
- Tick and legal load 12:00:00 in the same cycle -> time = 12:00:00, sec_pulse = 0. The next tick gives 12:00:01.
- run = 0 across 3 slow_clk_in edges -> time unchanged and no pulses. run = 1 -> the next edge increments by exactly 1.
- Assert reset while in ACK at 05:30:15 -> next cycle all fields are 0x00, load_ready = 1 and state is READY.

Source files
------------

// File: rtl/time_pkg.sv
// Shared types, constants and BCD helpers for the hh:mm:ss timekeeping block.
package time_pkg;

  typedef logic [7:0] bcd2_t;

  typedef enum logic {
    READY = 1'b0,
    ACK   = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX  = 4'd5;

  // Two-digit BCD encoding of a small constant (0..99), used at elaboration.
  function automatic bcd2_t to_bcd(input int unsigned n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // Valid packed BCD compares in the same order as its numeric value,
  // so range checks below are done on the BCD codes directly.
  function automatic logic is_legal_time(input bcd2_t hh,
                                         input bcd2_t mm,
                                         input bcd2_t ss,
                                         input int unsigned hour_limit,
                                         input int unsigned sec_limit);
    logic ok;
    ok = (hh[7:4] <= BCD_MAX_DIGIT) && (hh[3:0] <= BCD_MAX_DIGIT) &&
         (mm[7:4] <= SEC_TENS_MAX)  && (mm[3:0] <= BCD_MAX_DIGIT) &&
         (ss[7:4] <= SEC_TENS_MAX)  && (ss[3:0] <= BCD_MAX_DIGIT);
    ok = ok && (hh < to_bcd(hour_limit)) &&
         (mm < to_bcd(sec_limit)) && (ss < to_bcd(sec_limit));
    return ok;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with synchronous load; one per time field.
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter int unsigned MODULUS = 60
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry_out
);

  localparam bcd2_t LAST = to_bcd(MODULUS - 1);

  logic [3:0] tens;
  logic [3:0] units;

  assign tens      = value[7:4];
  assign units     = value[3:0];
  assign carry_out = inc & (value == LAST);

  always_ff @(posedge clock_in) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      if (value == LAST)
        value <= '0;
      else if (units == BCD_MAX_DIGIT)
        value <= {tens + 4'd1, 4'd0};
      else
        value <= {tens, units + 4'd1};
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// hh:mm:ss BCD time counter driven by rising edges of the 1 Hz divider output,
// with run/stop control and a validated one-shot load handshake.
module bcd_time_counter
  import time_pkg::*;
#(
  parameter int unsigned HOUR_LIMIT = 24,
  parameter int unsigned SEC_LIMIT  = 60
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       slow_clk_in,
  input  logic       run,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       load_err
);

  state_t state;
  state_t next_state;

  logic slow_q;
  logic tick;
  logic load_legal;
  logic load_accept;
  logic load_reject;
  logic count_en;
  logic ss_carry;
  logic mm_carry;
  logic hh_carry;

  assign tick       = slow_clk_in & ~slow_q;
  assign load_legal = is_legal_time(load_hh, load_mm, load_ss, HOUR_LIMIT, SEC_LIMIT);
  // An accepted load overrides the tick on the same edge.
  assign count_en   = tick & run & ~load_accept;

  always_ff @(posedge clock_in) begin
    if (reset)
      state <= READY;
    else
      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    load_accept = 1'b0;
    load_reject = 1'b0;
    case (state)
      READY: begin
        if (load_valid) begin
          if (load_legal) begin
            load_accept = 1'b1;
            next_state  = ACK;
          end else begin
            load_reject = 1'b1;
          end
        end
      end
      ACK:     next_state = READY;
      default: next_state = READY;
    endcase
  end

  // Pulses and load_ready are registered alongside the counters they describe.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      slow_q     <= 1'b1;
      sec_pulse  <= 1'b0;
      day_pulse  <= 1'b0;
      load_err   <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      slow_q     <= slow_clk_in;
      sec_pulse  <= count_en;
      day_pulse  <= hh_carry;
      load_err   <= load_reject;
      load_ready <= (next_state == READY);
    end
  end

  bcd_mod_counter #(.MODULUS(SEC_LIMIT)) u_ss (
    .clock_in  (clock_in),
    .reset     (reset),
    .inc       (count_en),
    .load      (load_accept),
    .load_val  (load_ss),
    .value     (seconds),
    .carry_out (ss_carry)
  );

  bcd_mod_counter #(.MODULUS(SEC_LIMIT)) u_mm (
    .clock_in  (clock_in),
    .reset     (reset),
    .inc       (ss_carry),
    .load      (load_accept),
    .load_val  (load_mm),
    .value     (minutes),
    .carry_out (mm_carry)
  );

  bcd_mod_counter #(.MODULUS(HOUR_LIMIT)) u_hh (
    .clock_in  (clock_in),
    .reset     (reset),
    .inc       (mm_carry),
    .load      (load_accept),
    .load_val  (load_hh),
    .value     (hours),
    .carry_out (hh_carry)
  );

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed self-checking bench for bcd_time_counter with hand-computed expectations.
module tb_bcd_time_counter;

  logic       clock_in = 1'b0;
  logic       reset;
  logic       slow_clk_in;
  logic       run;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       sec_pulse;
  logic       day_pulse;
  logic       load_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  bcd_time_counter #(.HOUR_LIMIT(24), .SEC_LIMIT(60)) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .slow_clk_in (slow_clk_in),
    .run         (run),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_hh     (load_hh),
    .load_mm     (load_mm),
    .load_ss     (load_ss),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .sec_pulse   (sec_pulse),
    .day_pulse   (day_pulse),
    .load_err    (load_err)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input logic [23:0] exp);
    check(tag, {hours, minutes, seconds}, exp);
  endtask

  // Advance to just after the next active edge.
  task automatic cyc();
    @(posedge clock_in);
    #1;
  endtask

  // Low phase then high phase of slow_clk_in; returns just after the counting edge.
  task automatic slow_edge();
    slow_clk_in = 1'b0;
    cyc();
    slow_clk_in = 1'b1;
    cyc();
  endtask

  task automatic load(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    load_valid = 1'b1;
    load_hh = hh;
    load_mm = mm;
    load_ss = ss;
    cyc();
    load_valid = 1'b0;
  endtask

  logic [23:0] bad_vec [3];

  initial begin
    bad_vec[0] = 24'h245909;
    bad_vec[1] = 24'h096009;
    bad_vec[2] = 24'h09591A;

    reset = 1'b1; slow_clk_in = 1'b1; run = 1'b1; load_valid = 1'b0;
    load_hh = '0; load_mm = '0; load_ss = '0;
    cyc(); cyc();
    reset = 1'b0;
    @(negedge clock_in);
    check_time("reset_time", 24'h000000);
    check("reset_ready", 24'(load_ready), 24'd1);
    check("reset_pulses", 24'({sec_pulse, day_pulse, load_err}), 24'd0);
    cyc(); cyc();
    @(negedge clock_in);
    check("no_tick_high_at_release", 24'(sec_pulse), 24'd0);
    check_time("still_zero", 24'h000000);

    slow_edge();
    @(negedge clock_in);
    check_time("first_tick", 24'h000001);
    check("first_sec_pulse", 24'(sec_pulse), 24'd1);
    cyc();
    @(negedge clock_in);
    check("sec_pulse_one_cycle", 24'(sec_pulse), 24'd0);

    load(8'h23, 8'h59, 8'h58);
    @(negedge clock_in);
    check_time("load_235958", 24'h235958);
    check("ack_ready_low", 24'(load_ready), 24'd0);
    cyc();
    @(negedge clock_in);
    check("ack_one_cycle", 24'(load_ready), 24'd1);
    slow_edge();
    @(negedge clock_in);
    check_time("tick_235959", 24'h235959);
    check("no_day_early", 24'(day_pulse), 24'd0);
    slow_edge();
    @(negedge clock_in);
    check_time("wrap_000000", 24'h000000);
    check("day_pulse", 24'({day_pulse, sec_pulse}), 24'd3);
    cyc();
    @(negedge clock_in);
    check("day_pulse_one_cycle", 24'(day_pulse), 24'd0);

    load(8'h09, 8'h59, 8'h09);
    @(negedge clock_in);
    check_time("load_095909", 24'h095909);
    cyc();
    for (int i = 0; i < 3; i++) begin
      load(bad_vec[i][23:16], bad_vec[i][15:8], bad_vec[i][7:0]);
      @(negedge clock_in);
      check($sformatf("bad_load_err_%0d", i), 24'({load_err, load_ready}), 24'd3);
      check_time($sformatf("bad_load_keep_%0d", i), 24'h095909);
      cyc();
      @(negedge clock_in);
      check($sformatf("bad_err_one_cycle_%0d", i), 24'(load_err), 24'd0);
    end

    slow_clk_in = 1'b0;
    cyc();
    slow_clk_in = 1'b1;
    load(8'h12, 8'h00, 8'h00);
    @(negedge clock_in);
    check_time("load_beats_tick", 24'h120000);
    check("load_beats_tick_pulse", 24'(sec_pulse), 24'd0);
    cyc();
    slow_edge();
    @(negedge clock_in);
    check_time("after_load_tick", 24'h120001);

    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      slow_edge();
      @(negedge clock_in);
      check($sformatf("stopped_pulse_%0d", i), 24'(sec_pulse), 24'd0);
    end
    check_time("stopped_hold", 24'h120001);
    run = 1'b1;
    slow_edge();
    @(negedge clock_in);
    check_time("resume_inc", 24'h120002);

    slow_clk_in = 1'b0;
    cyc();
    slow_clk_in = 1'b1;
    load(8'h25, 8'h00, 8'h00);
    @(negedge clock_in);
    check_time("tick_with_reject", 24'h120003);
    check("tick_with_reject_flags", 24'({sec_pulse, load_err}), 24'd3);

    load(8'h05, 8'h30, 8'h15);
    @(negedge clock_in);
    check_time("load_053015", 24'h053015);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock_in);
    check_time("reset_in_ack", 24'h000000);
    check("reset_in_ack_ready", 24'(load_ready), 24'd1);
    load(8'h01, 8'h02, 8'h03);
    @(negedge clock_in);
    check_time("ready_after_reset", 24'h010203);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
